// File: rtl/xdma_grant_arbiter.sv
// rtl/xdma_grant_arbiter.sv - round-robin grant arbiter feeding a grant FIFO for remote DMA requests
//
// Each request channel runs an IDLE -> PENDING -> WAIT_FINISH handshake. One PENDING
// channel per cycle is chosen round-robin. Its grant is captured into a small FIFO.
// The FIFO head is presented to the remote side with a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_ready_to_transfer_i      per-channel ready_to_transfer
//   req_dma_type_i               per-channel dma_type (1 = remote-initiated)
//   req_dma_id_i                 per-channel task id, channel c at [c*IdWidth +: IdWidth]
//   req_src_addr_i               per-channel source address, channel c at [c*AddrWidth +: AddrWidth]
//   grant_valid_o/grant_ready_i  grant handshake for the FIFO head
//   grant_dma_id_o, grant_from_o, grant_remote_addr_o, grant_chan_o
//                                head-of-FIFO payload, zero while the FIFO is empty
//   chan_busy_o                  channel is not IDLE
//   timeout_o                    sticky per-channel WAIT_FINISH timeout flag
//   fifo_count_o                 grant FIFO occupancy
module xdma_grant_arbiter #(
  parameter int unsigned          NumChannels     = 4,
  parameter int unsigned          FifoDepth       = 4,
  parameter int unsigned          AddrWidth       = 48,
  parameter int unsigned          IdWidth         = 8,
  parameter int unsigned          ClusterSizeLog2 = 20,
  parameter logic [AddrWidth-1:0] MainMemBaseAddr = 48'h8000_0000,
  parameter logic [AddrWidth-1:0] MainMemEndAddr  = 48'h1_0000_0000,
  parameter logic [AddrWidth-1:0] GrantOffset     = 48'h100,
  parameter int unsigned          TimeoutCycles   = 1024,
  localparam int unsigned         ChanWidth       = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int unsigned         CountWidth      = $clog2(FifoDepth) + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumChannels-1:0]           req_ready_to_transfer_i,
  input  logic [NumChannels-1:0]           req_dma_type_i,
  input  logic [NumChannels*IdWidth-1:0]   req_dma_id_i,
  input  logic [NumChannels*AddrWidth-1:0] req_src_addr_i,
  output logic                             grant_valid_o,
  input  logic                             grant_ready_i,
  output logic [IdWidth-1:0]               grant_dma_id_o,
  output logic [AddrWidth-1:0]             grant_from_o,
  output logic [AddrWidth-1:0]             grant_remote_addr_o,
  output logic [ChanWidth-1:0]             grant_chan_o,
  output logic [NumChannels-1:0]           chan_busy_o,
  output logic [NumChannels-1:0]           timeout_o,
  output logic [CountWidth-1:0]            fifo_count_o
);

  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);
  localparam logic [TmoWidth-1:0]   TmoLimit      = TmoWidth'(TimeoutCycles);
  localparam logic [TmoWidth-1:0]   TmoLimitM1    = TmoWidth'(TimeoutCycles - 1);
  localparam logic [AddrWidth-1:0]  ClusterSize   = AddrWidth'(1) << ClusterSizeLog2;
  localparam logic [AddrWidth-1:0]  ClusterMask   = ~(ClusterSize - AddrWidth'(1));
  localparam logic [AddrWidth-1:0]  MainMemGrant  = MainMemEndAddr - GrantOffset;
  localparam logic [CountWidth-1:0] FullCount     = CountWidth'(FifoDepth);
  localparam logic [ChanWidth-1:0]  LastChan      = ChanWidth'(NumChannels - 1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    WAIT_FINISH
  } chan_state_e;

  chan_state_e state_q [NumChannels];
  chan_state_e state_d [NumChannels];

  logic [NumChannels-1:0] req;
  logic [NumChannels-1:0] eligible;
  logic [ChanWidth-1:0]   rr_ptr_q;
  logic                   any_win;
  logic [ChanWidth-1:0]   win_idx;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;

  logic [IdWidth-1:0]     id_mem    [FifoDepth];
  logic [AddrWidth-1:0]   from_mem  [FifoDepth];
  logic [AddrWidth-1:0]   raddr_mem [FifoDepth];
  logic [ChanWidth-1:0]   chan_mem  [FifoDepth];
  logic [PtrWidth-1:0]    wr_ptr_q;
  logic [PtrWidth-1:0]    rd_ptr_q;
  logic [CountWidth-1:0]  count_q;

  logic [TmoWidth-1:0]    tmo_cnt_q [NumChannels];
  logic [NumChannels-1:0] timeout_q;

  logic [IdWidth-1:0]     win_id;
  logic [AddrWidth-1:0]   win_src;
  logic [AddrWidth-1:0]   win_raddr;

  assign req       = req_ready_to_transfer_i & req_dma_type_i;
  assign fifo_full = (count_q == FullCount);
  // No bypass: a full FIFO refuses the push even when the head pops this cycle.
  assign push      = any_win && !fifo_full;
  assign pop       = (count_q != '0) && grant_ready_i;

  // A withdrawing channel (req low) is never eligible, so withdrawal beats push.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NumChannels; c++) begin
      eligible[c] = (state_q[c] == PENDING) && req[c];
    end
  end

  // Round-robin: first eligible channel at or above the pointer, else wrap to the lowest.
  always_comb begin
    any_win = 1'b0;
    win_idx = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (!any_win && eligible[c] && (ChanWidth'(c) >= rr_ptr_q)) begin
        any_win = 1'b1;
        win_idx = ChanWidth'(c);
      end
    end
    for (int c = 0; c < NumChannels; c++) begin
      if (!any_win && eligible[c]) begin
        any_win = 1'b1;
        win_idx = ChanWidth'(c);
      end
    end
  end

  always_comb begin
    win_id  = '0;
    win_src = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (win_idx == ChanWidth'(c)) begin
        win_id  = req_dma_id_i[c*IdWidth +: IdWidth];
        win_src = req_src_addr_i[c*AddrWidth +: AddrWidth];
      end
    end
  end

  // Main-memory sources map to a fixed slot. Cluster sources map to the top of the next cluster window.
  always_comb begin
    if (win_src >= MainMemBaseAddr) begin
      win_raddr = MainMemGrant;
    end else begin
      win_raddr = ((win_src & ClusterMask) + ClusterSize) - GrantOffset;
    end
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        IDLE: begin
          if (req[c]) state_d[c] = PENDING;
        end
        PENDING: begin
          if (!req[c]) begin
            state_d[c] = IDLE;
          end else if (push && (win_idx == ChanWidth'(c))) begin
            state_d[c] = WAIT_FINISH;
          end
        end
        WAIT_FINISH: begin
          if (!req[c]) state_d[c] = IDLE;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChannels; c++) state_q[c] <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        rr_ptr_q <= (win_idx == LastChan) ? '0 : win_idx + ChanWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CountWidth'(1);
        2'b01:   count_q <= count_q - CountWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr_q]    <= win_id;
      from_mem[wr_ptr_q]  <= win_src;
      raddr_mem[wr_ptr_q] <= win_raddr;
      chan_mem[wr_ptr_q]  <= win_idx;
    end
  end

  // The timeout counter is for monitoring only. It never feeds back into the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChannels; c++) tmo_cnt_q[c] <= '0;
      timeout_q <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if ((state_q[c] == PENDING) && (state_d[c] == WAIT_FINISH)) begin
          tmo_cnt_q[c] <= '0;
        end else if ((state_q[c] == WAIT_FINISH) && (tmo_cnt_q[c] != TmoLimit)) begin
          tmo_cnt_q[c] <= tmo_cnt_q[c] + TmoWidth'(1);
          if (tmo_cnt_q[c] == TmoLimitM1) timeout_q[c] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      chan_busy_o[c] = (state_q[c] != IDLE);
    end
  end

  assign grant_valid_o       = (count_q != '0);
  assign grant_dma_id_o      = grant_valid_o ? id_mem[rd_ptr_q]    : '0;
  assign grant_from_o        = grant_valid_o ? from_mem[rd_ptr_q]  : '0;
  assign grant_remote_addr_o = grant_valid_o ? raddr_mem[rd_ptr_q] : '0;
  assign grant_chan_o        = grant_valid_o ? chan_mem[rd_ptr_q]  : '0;
  assign timeout_o           = timeout_q;
  assign fifo_count_o        = count_q;

endmodule

// File: tb/tb_xdma_grant_arbiter.sv
// tb/tb_xdma_grant_arbiter.sv - self-checking bench for xdma_grant_arbiter
module tb_xdma_grant_arbiter;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int AW = 48;
  localparam int IW = 8;
  localparam int T  = 20;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    rdy;
  logic [N-1:0]    typ;
  logic [N*IW-1:0] ids;
  logic [N*AW-1:0] srcs;
  logic            grant_ready;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;
  logic [AW-1:0]   grant_from;
  logic [AW-1:0]   grant_raddr;
  logic [1:0]      grant_chan;
  logic [N-1:0]    chan_busy;
  logic [N-1:0]    timeout;
  logic [2:0]      fifo_count;

  always #5 clk_i = ~clk_i;

  xdma_grant_arbiter #(
    .NumChannels  (N),
    .FifoDepth    (D),
    .TimeoutCycles(T)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .req_ready_to_transfer_i(rdy),
    .req_dma_type_i         (typ),
    .req_dma_id_i           (ids),
    .req_src_addr_i         (srcs),
    .grant_valid_o          (grant_valid),
    .grant_ready_i          (grant_ready),
    .grant_dma_id_o         (grant_id),
    .grant_from_o           (grant_from),
    .grant_remote_addr_o    (grant_raddr),
    .grant_chan_o           (grant_chan),
    .chan_busy_o            (chan_busy),
    .timeout_o              (timeout),
    .fifo_count_o           (fifo_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channel phases as small integers and the grant FIFO as a queue.
  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] from;
    logic [AW-1:0] raddr;
    int            chan;
  } grant_t;

  grant_t mq[$];
  int     m_phase [N];   // 0 idle, 1 waiting for a slot, 2 granted and waiting for release
  int     m_cnt   [N];
  bit     m_to    [N];
  int     m_ptr;

  function automatic logic [AW-1:0] ref_remote(input logic [AW-1:0] src);
    logic [AW-1:0] win;
    win = 48'd1 << 20;
    if (src >= 48'h8000_0000) return 48'h1_0000_0000 - 48'h100;
    return (src / win + 48'd1) * win - 48'h100;
  endfunction

  task automatic model_step();
    bit     r [N];
    int     winner;
    bit     do_pop;
    grant_t g;
    if (rst_i) begin
      mq.delete();
      for (int c = 0; c < N; c++) begin
        m_phase[c] = 0; m_cnt[c] = 0; m_to[c] = 0;
      end
      m_ptr = 0;
      return;
    end
    for (int c = 0; c < N; c++) r[c] = rdy[c] && typ[c];
    do_pop = (mq.size() != 0) && grant_ready;
    winner = -1;
    if (mq.size() < D) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (winner < 0 && m_phase[c] == 1 && r[c]) winner = c;
      end
    end
    for (int c = 0; c < N; c++) begin
      case (m_phase[c])
        0: if (r[c]) m_phase[c] = 1;
        1: begin
          if (!r[c]) m_phase[c] = 0;
          else if (c == winner) begin m_phase[c] = 2; m_cnt[c] = 0; end
        end
        default: begin
          if (m_cnt[c] < T) begin
            m_cnt[c]++;
            if (m_cnt[c] == T) m_to[c] = 1;
          end
          if (!r[c]) m_phase[c] = 0;
        end
      endcase
    end
    if (do_pop) void'(mq.pop_front());
    if (winner >= 0) begin
      g.id    = ids[winner*IW +: IW];
      g.from  = srcs[winner*AW +: AW];
      g.raddr = ref_remote(g.from);
      g.chan  = winner;
      mq.push_back(g);
      m_ptr = (winner + 1) % N;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] busy, to;
    for (int c = 0; c < N; c++) begin
      busy[c] = (m_phase[c] != 0);
      to[c]   = m_to[c];
    end
    chk("valid", 64'(grant_valid), 64'(mq.size() != 0));
    chk("count", 64'(fifo_count), 64'(mq.size()));
    chk("busy", 64'(chan_busy), 64'(busy));
    chk("timeout", 64'(timeout), 64'(to));
    if (mq.size() != 0) begin
      chk("id", 64'(grant_id), 64'(mq[0].id));
      chk("from", 64'(grant_from), 64'(mq[0].from));
      chk("raddr", 64'(grant_raddr), 64'(mq[0].raddr));
      chk("chan", 64'(grant_chan), 64'(mq[0].chan));
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_ch(input int c, input bit r, input bit t, input logic [IW-1:0] id,
                        input logic [AW-1:0] src);
    rdy[c] = r;
    typ[c] = t;
    ids[c*IW +: IW] = id;
    srcs[c*AW +: AW] = src;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; rdy = '0; typ = '0; grant_ready = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] rdy;
    logic [N-1:0] typ;
    logic         ready;
    logic         exp_valid;
    int           exp_count;
    logic [N-1:0] exp_busy;
    int           exp_chan;
  } vec_t;

  vec_t tbl [11];
  int   ch1_grants;

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[1]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 0, 4'b0001, 0};
    tbl[2]  = '{4'b0001, 4'b0001, 1'b0, 1'b1, 1, 4'b0001, 0};
    tbl[3]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 0, 4'b0001, 0};
    tbl[4]  = '{4'b0000, 4'b0001, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[5]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[6]  = '{4'b0110, 4'b0110, 1'b0, 1'b0, 0, 4'b0110, 0};
    tbl[7]  = '{4'b0110, 4'b0110, 1'b0, 1'b1, 1, 4'b0110, 1};
    tbl[8]  = '{4'b0110, 4'b0110, 1'b0, 1'b1, 2, 4'b0110, 1};
    tbl[9]  = '{4'b0110, 4'b0110, 1'b1, 1'b1, 1, 4'b0110, 2};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 0};

    rst_i = 1'b1; rdy = '0; typ = '0; ids = '0; srcs = '0; grant_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(grant_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(chan_busy), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_id", 64'(grant_id), 64'd0);
    chk("rst_from", 64'(grant_from), 64'd0);
    chk("rst_raddr", 64'(grant_raddr), 64'd0);
    chk("rst_chan", 64'(grant_chan), 64'd0);
    rst_i = 1'b0;

    for (int c = 0; c < N; c++) set_ch(c, 1'b0, 1'b0, 8'(8'h10 + c), 48'(48'h0030_0000 + c));
    for (int i = 0; i < 11; i++) begin
      rdy = tbl[i].rdy; typ = tbl[i].typ; grant_ready = tbl[i].ready;
      tick();
      chk("tbl_valid", 64'(grant_valid), 64'(tbl[i].exp_valid));
      chk("tbl_count", 64'(fifo_count), 64'(tbl[i].exp_count));
      chk("tbl_busy", 64'(chan_busy), 64'(tbl[i].exp_busy));
      if (tbl[i].exp_valid) chk("tbl_chan", 64'(grant_chan), 64'(tbl[i].exp_chan));
    end

    // Single cluster-range request: latency and remote address.
    reset_dut();
    set_ch(0, 1'b1, 1'b1, 8'd5, 48'h0010_2345);
    tick();
    chk("lat_t1_valid", 64'(grant_valid), 64'd0);
    chk("lat_t1_busy", 64'(chan_busy), 64'b0001);
    tick();
    chk("lat_t2_valid", 64'(grant_valid), 64'd1);
    chk("lat_raddr", 64'(grant_raddr), 64'h001F_FF00);
    chk("lat_from", 64'(grant_from), 64'h0010_2345);
    chk("lat_id", 64'(grant_id), 64'd5);
    chk("lat_chan", 64'(grant_chan), 64'd0);
    set_ch(0, 1'b1, 1'b1, 8'd77, 48'h0055_0000);
    tick();
    chk("hold_raddr", 64'(grant_raddr), 64'h001F_FF00);
    chk("hold_id", 64'(grant_id), 64'd5);

    // Main-memory source.
    reset_dut();
    set_ch(3, 1'b1, 1'b1, 8'd9, 48'h9000_0000);
    tick();
    tick();
    chk("mm_raddr", 64'(grant_raddr), 64'hFFFF_FF00);
    chk("mm_chan", 64'(grant_chan), 64'd3);

    // All channels at once: grants in channel order, one per cycle.
    reset_dut();
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b1, 8'(c), 48'(48'h0010_0000 * c));
    grant_ready = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("rr_valid", 64'(grant_valid), 64'd1);
      chk("rr_chan", 64'(grant_chan), 64'(k));
    end

    // Full FIFO back-pressure, then withdrawal of a pending channel.
    reset_dut();
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b1, 8'(8'h20 + c), 48'(48'h0040_0000 + c));
    repeat (6) tick();
    chk("full_count", 64'(fifo_count), 64'd4);
    rdy[1] = 1'b0; rdy[0] = 1'b0;
    tick();
    rdy[1] = 1'b1; rdy[0] = 1'b1;
    tick();
    tick();
    chk("full_busy1", 64'(chan_busy[1]), 64'd1);
    chk("full_count2", 64'(fifo_count), 64'd4);
    chk("full_head", 64'(grant_chan), 64'd0);
    rdy[1] = 1'b0;
    tick();
    chk("wd_busy1", 64'(chan_busy[1]), 64'd0);
    grant_ready = 1'b1;
    ch1_grants = 0;
    for (int k = 0; k < 10; k++) begin
      if (grant_valid && grant_chan == 2'd1) ch1_grants++;
      tick();
    end
    chk("wd_ch1_grants", 64'(ch1_grants), 64'd1);
    chk("drain_count", 64'(fifo_count), 64'd0);

    // Timeout on channel 2, sticky until reset.
    reset_dut();
    set_ch(2, 1'b1, 1'b1, 8'd2, 48'h0010_0000);
    grant_ready = 1'b1;
    tick();
    tick();
    repeat (10) tick();
    chk("tmo_early", 64'(timeout[2]), 64'd0);
    repeat (15) tick();
    chk("tmo_set", 64'(timeout[2]), 64'd1);
    rdy[2] = 1'b0;
    repeat (3) tick();
    chk("tmo_sticky", 64'(timeout[2]), 64'd1);
    grant_ready = 1'b0;
    set_ch(0, 1'b1, 1'b1, 8'd1, 48'h0000_1000);
    repeat (3) tick();
    chk("tmo_q_count", 64'(fifo_count), 64'd1);
    rst_i = 1'b1;
    tick();
    chk("tmo_rst_to", 64'(timeout), 64'd0);
    chk("tmo_rst_count", 64'(fifo_count), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("rst_reenter", 64'(chan_busy[0]), 64'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) rdy[c] = ~rdy[c];
        if ($urandom_range(0, 7) == 0) typ[c] = ~typ[c];
        ids[c*IW +: IW] = 8'($urandom);
        srcs[c*AW +: AW] = {($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0, 32'($urandom)};
      end
      grant_ready = ($urandom_range(0, 2) != 0);
      rst_i = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xdma_grant_arbiter.md
XDMA_GRANT_ARBITER -- requirements
Module: xdma_grant_arbiter

Interface
REQ-001 SHALL have parameter NumChannels, default 4: number of independent incoming request channels (1..16).
REQ-002 SHALL have parameter FifoDepth, default 4: grant FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter AddrWidth, default 48: address width.
REQ-004 SHALL have parameter IdWidth, default 8: DMA task-id width.
REQ-005 SHALL have parameter ClusterSizeLog2, default 20: log2 of cluster address window.
REQ-006 SHALL have parameters MainMemBaseAddr (default 48'h8000_0000), MainMemEndAddr (default 48'h1_0000_0000) and GrantOffset (default 48'h100): address constants for remote-address computation.
REQ-007 SHALL have parameter TimeoutCycles, default 1024: max cycles a channel may stay in WAIT_FINISH.
REQ-008 clk_i  input  1  clock; one clock domain, all logic on rising edge.
REQ-009 rst_i  input  1  reset; synchronous, active-high.
REQ-010 req_ready_to_transfer_i  input  NumChannels  per-channel ready_to_transfer.
REQ-011 req_dma_type_i  input  NumChannels  per-channel dma_type (1 = remote-initiated).
REQ-012 req_dma_id_i  input  NumChannels*IdWidth  per-channel task id, channel c at bits [c*IdWidth +: IdWidth].
REQ-013 req_src_addr_i  input  NumChannels*AddrWidth  per-channel source address, packed likewise.
REQ-014 grant_valid_o / grant_ready_i  output / input  1 / 1  grant valid/ready handshake to remote.
REQ-015 grant_dma_id_o, grant_from_o, grant_remote_addr_o, grant_chan_o  output  IdWidth, AddrWidth, AddrWidth, $clog2(NumChannels) (min 1)  head-of-FIFO grant payload.
REQ-016 chan_busy_o  output  NumChannels  channel not IDLE; timeout_o  output  NumChannels  sticky timeout flag; fifo_count_o  output  $clog2(FifoDepth)+1  FIFO occupancy.

Function
REQ-017 Per channel, req_c = ready_to_transfer[c] AND dma_type[c].
REQ-018 Per-channel FSM states IDLE, PENDING, WAIT_FINISH; IDLE->PENDING when req_c=1.
REQ-019 PENDING->WAIT_FINISH on the cycle its entry is pushed; PENDING->IDLE if req_c=0 (withdrawal, no entry pushed, withdrawal has priority over push).
REQ-020 WAIT_FINISH->IDLE when req_c=0; a new request needs at least one IDLE cycle.
REQ-021 One push per cycle max; round-robin among PENDING channels with req_c=1, pointer starts at channel 0, moves to winner+1 (mod NumChannels) after each push.
REQ-022 Push only when FIFO not full (count < FifoDepth); no bypass, push not allowed into a full FIFO even if pop occurs same cycle.
REQ-023 Pop when grant_valid_o AND grant_ready_i; simultaneous push and pop allowed when not full, count unchanged.
REQ-024 grant_valid_o = (count != 0), registered-storage FIFO; payload stable while valid and not ready.
REQ-025 Entry payload captured at push: dma_id, from = src_addr, chan = winner index, remote_addr.
REQ-026 remote_addr = MainMemEndAddr - GrantOffset if src_addr >= MainMemBaseAddr, else ((src_addr with low ClusterSizeLog2 bits cleared) + 2^ClusterSizeLog2) - GrantOffset; all arithmetic modulo 2^AddrWidth.
REQ-027 Latency: req_c rises cycle t, PENDING at t+1, earliest push at t+1, grant_valid_o high at t+2.
REQ-028 Per-channel counter cleared on entry to WAIT_FINISH, increments each WAIT_FINISH cycle, saturates; reaching TimeoutCycles sets timeout_o[c], which stays set until reset; FSM behaviour unaffected.
REQ-029 Changes in req_dma_id_i/req_src_addr_i after push SHALL NOT alter queued entries.

Reset
REQ-030 With rst_i=1 at a rising edge: all FSMs IDLE, RR pointer 0, FIFO empty, counters 0, timeout_o 0.
REQ-031 Outputs after reset: grant_valid_o 0, fifo_count_o 0, chan_busy_o 0, grant payload outputs 0.
REQ-032 Reset mid-operation SHALL discard queued grants; held requests re-enter PENDING on the first cycle after reset release.

Verification
REQ-033 Single channel: ch0 req, src 0x0010_2345, id 5 -> grant_valid_o at t+2, remote_addr 0x0020_0000-0x100=0x001F_FF00, from 0x0010_2345, chan 0.
REQ-034 Main memory: src 0x9000_0000 -> remote_addr 0xFFFF_FF00.
REQ-035 All 4 channels req same cycle, grant_ready_i=1 -> grants in order ch0,1,2,3, one per cycle.
REQ-036 grant_ready_i=0, 6 requests over channels with depth 4 -> fifo_count_o stops at 4, excess channels stay PENDING, payload stable; release ready -> remaining pushed, none lost or duplicated.
REQ-037 ch1 withdraws while PENDING behind full FIFO -> no ch1 grant emitted, chan_busy_o[1] drops next cycle.
REQ-038 ch2 held in WAIT_FINISH for TimeoutCycles -> timeout_o[2]=1 and stays 1 after req drops; rst_i pulse clears it and empties FIFO.
